// File: rtl/contactor_sequencer_if.sv
// Operator/interlock/feedback handshake between a contactor sequencer and its
// surroundings. The sequencer takes the slave side.
interface contactor_sequencer_if;
  logic       i_Req;
  logic       i_Permit;
  logic       i_Fb;
  logic       i_FaultClr;
  logic       o_Coil;
  logic       o_Closed;
  logic       o_Busy;
  logic       o_Fault;
  logic [1:0] o_FaultCode;

  modport master (
    output i_Req, i_Permit, i_Fb, i_FaultClr,
    input  o_Coil, o_Closed, o_Busy, o_Fault, o_FaultCode
  );

  modport slave (
    input  i_Req, i_Permit, i_Fb, i_FaultClr,
    output o_Coil, o_Closed, o_Busy, o_Fault, o_FaultCode
  );
endinterface

// File: rtl/contactor_sequencer.sv
// Per-contactor close/open sequencer: drives the coil, debounces the aux
// feedback and supervises close/open completion with timeouts.
module contactor_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CLOSE_TIMEOUT   = 1000,
  parameter int OPEN_TIMEOUT    = 1000
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  contactor_sequencer_if.slave  bus
);
  localparam int TMAX = (CLOSE_TIMEOUT > OPEN_TIMEOUT) ? CLOSE_TIMEOUT : OPEN_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_OPEN, ST_CLOSING, ST_CLOSED, ST_OPENING, ST_FAULT
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    code_q, code_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          closed_q, closed_d;

  // Feedback debounce: only an unbroken run of differing samples flips closed_q.
  always_comb begin
    cnt_d    = '0;
    closed_d = closed_q;
    if (sync2_q != closed_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) closed_d = ~closed_q;
      else                                   cnt_d    = cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    case (state_q)
      ST_OPEN: begin
        if (closed_q) begin
          state_d = ST_FAULT;
          code_d  = 2'd3;
        end else if (bus.i_Req && bus.i_Permit) begin
          state_d = ST_CLOSING;
        end
      end
      ST_CLOSING: begin
        if (!bus.i_Permit)                          state_d = ST_OPENING;
        else if (closed_q)                          state_d = ST_CLOSED;
        else if (timer_q == TW'(CLOSE_TIMEOUT - 1)) begin
          state_d = ST_FAULT;
          code_d  = 2'd1;
        end
      end
      ST_CLOSED: begin
        if (!bus.i_Req || !bus.i_Permit) state_d = ST_OPENING;
        else if (!closed_q) begin
          state_d = ST_FAULT;
          code_d  = 2'd2;
        end
      end
      ST_OPENING: begin
        if (!closed_q)                             state_d = ST_OPEN;
        else if (timer_q == TW'(OPEN_TIMEOUT - 1)) begin
          state_d = ST_FAULT;
          code_d  = 2'd3;
        end
      end
      ST_FAULT: begin
        // Acknowledge only takes effect once the contactor is seen open.
        if (bus.i_FaultClr && !closed_q) begin
          state_d = ST_OPEN;
          code_d  = 2'd0;
        end
      end
      default: begin
        state_d = ST_OPEN;
        code_d  = 2'd0;
      end
    endcase
  end

  // Timer counts cycles of residency; any state change restarts it.
  always_comb begin
    timer_d = '0;
    if (state_d == state_q && (state_q == ST_CLOSING || state_q == ST_OPENING))
      timer_d = timer_q + 1'b1;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q  <= ST_OPEN;
      code_q   <= 2'd0;
      timer_q  <= '0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      closed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      timer_q  <= timer_d;
      sync1_q  <= bus.i_Fb;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      closed_q <= closed_d;
    end
  end

  assign bus.o_Coil      = (state_q == ST_CLOSING) || (state_q == ST_CLOSED);
  assign bus.o_Closed    = closed_q;
  assign bus.o_Busy      = (state_q == ST_CLOSING) || (state_q == ST_OPENING);
  assign bus.o_Fault     = (state_q == ST_FAULT);
  assign bus.o_FaultCode = (state_q == ST_FAULT) ? code_q : 2'd0;
endmodule

// File: doc/contactor_sequencer.md
# contactor_sequencer

Per-contactor close/open sequencer sitting directly downstream of that contactor's ring interlock logic. Takes the operator close request and the interlock permit, drives the contactor coil, debounces the auxiliary-contact feedback, and supervises close/open completion with timeouts. Its debounced feedback output is the signal fed back to the interlock logic of every other contactor in the ring.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive synchronised samples required to accept a feedback change; must be ≥2.
- CLOSE_TIMEOUT, 1000: maximum cycles in CLOSING; must be > DEBOUNCE_CYCLES+2.
- OPEN_TIMEOUT, 1000: maximum cycles in OPENING; must be > DEBOUNCE_CYCLES+2.

- i_Clk  in  1  system clock, rising edge.
- i_Rst_n  in  1  asynchronous, active-low reset.
- i_Req  in  1  level close request (1 = want closed).
- i_Permit  in  1  interlock permit for this contactor (1 = closing allowed).
- i_Fb  in  1  raw auxiliary contact, asynchronous (1 = closed).
- i_FaultClr  in  1  single-cycle fault acknowledge.
- o_Coil  out  1  coil drive (1 = energise).
- o_Closed  out  1  debounced feedback.
- o_Busy  out  1  high in CLOSING or OPENING.
- o_Fault  out  1  high in FAULT.
- o_FaultCode  out  2  0 none, 1 fail-to-close, 2 unexpected dropout, 3 fail-to-open / stuck closed.

One clock; reset is asynchronous and active-low.

## Operation
- Feedback path: 2-flop synchroniser, then debounce counter. Counter clears whenever the synchronised value equals o_Closed; increments otherwise; o_Closed flips when the DEBOUNCE_CYCLES-th consecutive differing sample is taken (counter clears on the flip).
- State machine, Moore outputs: o_Coil=1 only in CLOSING and CLOSED.
- OPEN: o_Closed=1 → FAULT code 3; else i_Req&i_Permit → CLOSING.
- CLOSING: priority 1 ~i_Permit → OPENING (abort); 2 o_Closed=1 → CLOSED; 3 timer hits CLOSE_TIMEOUT → FAULT code 1.
- CLOSED: ~i_Req or ~i_Permit → OPENING; else o_Closed=0 → FAULT code 2.
- OPENING: o_Closed=0 → OPEN; else timer hits OPEN_TIMEOUT → FAULT code 3. i_Req/i_Permit ignored until OPEN.
- FAULT: coil off, i_Req ignored. i_FaultClr with o_Closed=0 → OPEN, code cleared; i_FaultClr with o_Closed=1 ignored (stays FAULT, code unchanged).
- Timer: cleared on entry to CLOSING/OPENING, increments each cycle in state; timeout transition taken on the edge where the state has been occupied TIMEOUT cycles. Feedback completion in the same cycle wins over timeout.
- o_FaultCode holds its value for the whole FAULT residency; 0 in every other state.

## Timing
- Reset (async assert): state OPEN, o_Coil=0, o_Closed=0, o_Busy=0, o_Fault=0, o_FaultCode=0, synchroniser, debounce counter and timer cleared. Reset mid-CLOSING/CLOSED drops coil immediately, not at next edge.
- Request latency: i_Req&i_Permit sampled at edge N → state CLOSING and o_Coil=1 after edge N.
- Permit loss: sampled at edge N in CLOSING/CLOSED → o_Coil=0 after edge N.
- Feedback latency: raw i_Fb change first sampled at edge 0 → o_Closed changes after edge DEBOUNCE_CYCLES+1; state advance on the following edge.
- Glitch shorter than DEBOUNCE_CYCLES synchronised samples never reaches o_Closed.
- i_FaultClr sampled at edge N → OPEN after edge N; new close request accepted from edge N+1.

## Test plan
- DEBOUNCE_CYCLES=4, timeouts 20. Normal close: i_Permit=1, i_Req=1 at edge 0, i_Fb rises 3 cycles after o_Coil → o_Coil=1 after edge 0, o_Closed=1 exactly 5 edges after first i_Fb sample, CLOSED, o_FaultCode=0; drop i_Req, i_Fb falls → OPENING then OPEN.
- Fail-to-close: i_Fb held 0 → after 20 cycles in CLOSING o_Fault=1, o_FaultCode=1, o_Coil=0; i_FaultClr → OPEN, code 0.
- Permit loss in CLOSED: i_Permit 1→0 → o_Coil=0 next edge, OPENING, o_Busy=1; i_Fb stays 1 → FAULT code 3 after 20 cycles; i_FaultClr ignored until o_Closed=0.
- Glitch: in OPEN, i_Fb pulse of 3 cycles → o_Closed stays 0, no fault; pulse of 8 cycles → o_Closed=1, FAULT code 3.
- Dropout: in CLOSED, i_Fb falls for 10 cycles → FAULT code 2, o_Coil=0.
- Async reset asserted mid-CLOSING → o_Coil=0 before next edge; all outputs at reset values; same-cycle completion vs timeout (i_Fb accepted on timeout cycle) → CLOSED, no fault.
